// File: rtl/ddiff_arb.sv
// ddiff_arb: round-robin shared sign-magnitude delayed-difference unit.
// Ports:
//   clk, rst               clock, async active-high reset
//   req, din_mag, din_sign per-channel sample requests (channel k at [k*W +: W])
//   gnt                    one-hot combinational grant (sample consumed)
//   clr_hist               synchronous clear of all channel histories
//   out_valid, out_ready   single-entry result register handshake
//   out_mag, out_sign      result A(n) - A(n-1), sign-magnitude, no -0
//   out_ch, out_ovf        producing channel, magnitude saturated flag
module ddiff_arb #(
    parameter int NCH = 4,
    parameter int W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*W-1:0]         din_mag,
    input  logic [NCH-1:0]           din_sign,
    output logic [NCH-1:0]           gnt,
    input  logic                     clr_hist,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_mag,
    output logic                     out_sign,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     out_ovf
);

    localparam int CW = $clog2(NCH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] ptr;

    logic [W-1:0]  hist_mag  [NCH];
    logic          hist_sign [NCH];

    logic          can_accept;
    logic          found;
    logic [CW-1:0] gidx;
    int            j;

    logic [W-1:0]  a_mag;
    logic          a_sign;
    logic [W-1:0]  b_mag;
    logic          b_sign;
    logic [W:0]    sum;
    logic [W-1:0]  r_mag;
    logic          r_sign;
    logic          r_ovf;

    assign out_valid  = (state == ST_FULL);
    assign can_accept = !out_valid || out_ready;

    // Scan upward from the pointer with wrap; first requester wins.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        j     = 0;
        if (!rst && can_accept) begin
            for (int i = 0; i < NCH; i++) begin
                j = int'(ptr) + i;
                if (j >= NCH) begin
                    j = j - NCH;
                end
                if (!found && req[j]) begin
                    found  = 1'b1;
                    gidx   = CW'(j);
                    gnt[j] = 1'b1;
                end
            end
        end
    end

    assign a_mag  = din_mag[gidx*W +: W];
    assign a_sign = din_sign[gidx];
    assign b_mag  = hist_mag[gidx];
    assign b_sign = hist_sign[gidx];
    assign sum    = {1'b0, a_mag} + {1'b0, b_mag};

    // Equal signs subtract magnitudes; opposite signs add them and
    // saturate on carry out. Sign of a zero result is forced positive.
    always_comb begin
        r_mag  = '0;
        r_sign = 1'b0;
        r_ovf  = 1'b0;
        if (a_sign == b_sign) begin
            if (a_mag >= b_mag) begin
                r_mag  = a_mag - b_mag;
                r_sign = a_sign;
            end else begin
                r_mag  = b_mag - a_mag;
                r_sign = !a_sign;
            end
        end else begin
            r_sign = a_sign;
            if (sum[W]) begin
                r_mag = '1;
                r_ovf = 1'b1;
            end else begin
                r_mag = sum[W-1:0];
            end
        end
        if (r_mag == '0) begin
            r_sign = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            out_mag  <= '0;
            out_sign <= 1'b0;
            out_ch   <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!found && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (found) begin
                out_mag  <= r_mag;
                out_sign <= r_sign;
                out_ch   <= gidx;
                out_ovf  <= r_ovf;
                if (gidx == CW'(NCH - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gidx + 1'b1;
                end
            end
        end
    end

    // Clear takes priority over the granted channel's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                hist_mag[k]  <= '0;
                hist_sign[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (clr_hist) begin
                    hist_mag[k]  <= '0;
                    hist_sign[k] <= 1'b0;
                end else if (gnt[k]) begin
                    hist_mag[k]  <= din_mag[k*W +: W];
                    hist_sign[k] <= din_sign[k] && (din_mag[k*W +: W] != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_ddiff_arb.sv
// tb_ddiff_arb: scoreboard bench for ddiff_arb.
// Expected results are queued at grant time and compared at handshake.
module tb_ddiff_arb;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int MAXM = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   req = '0;
    logic [NCH*W-1:0] din_mag = '0;
    logic [NCH-1:0]   din_sign = '0;
    logic [NCH-1:0]   gnt;
    logic             clr_hist = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_mag;
    logic             out_sign;
    logic [1:0]       out_ch;
    logic             out_ovf;

    always #5 clk = ~clk;

    ddiff_arb #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din_mag   (din_mag),
        .din_sign  (din_sign),
        .gnt       (gnt),
        .clr_hist  (clr_hist),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_sign  (out_sign),
        .out_ch    (out_ch),
        .out_ovf   (out_ovf)
    );

    typedef struct packed {
        logic [W-1:0] mag;
        logic         sign;
        logic [1:0]   ch;
        logic         ovf;
    } res_t;

    res_t           q[$];
    int             total = 0;
    int             bad = 0;
    int             m_mag[NCH];
    bit             m_sgn[NCH];
    int             m_ptr = 0;
    logic [NCH-1:0] last_gnt = '0;
    logic [NCH-1:0] pend = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_mag[c] = 0;
            m_sgn[c] = 1'b0;
        end
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] m, input logic s);
        din_mag[k*W +: W] = m;
        din_sign[k] = s;
    endtask

    // One clock: check outputs and grant at negedge, update model,
    // return 1 time unit after the next rising edge.
    task automatic tick();
        res_t           e;
        bit             can;
        logic [NCH-1:0] eg;
        int             k, a, b, d, ab;
        logic [W-1:0]   am;
        @(negedge clk);
        if (q.size() != 0) begin
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("mag", {16'd0, out_mag}, {16'd0, q[0].mag});
            chk("sign", {31'd0, out_sign}, {31'd0, q[0].sign});
            chk("ch", {30'd0, out_ch}, {30'd0, q[0].ch});
            chk("ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
        end else begin
            chk("valid", {31'd0, out_valid}, 32'd0);
        end
        can = (q.size() == 0) || out_ready;
        eg = '0;
        k = -1;
        if (!rst && can) begin
            for (int i = 0; i < NCH; i++) begin
                if (k < 0 && req[(m_ptr + i) % NCH]) begin
                    k = (m_ptr + i) % NCH;
                end
            end
        end
        if (k >= 0) begin
            eg[k] = 1'b1;
        end
        chk("gnt", {28'd0, gnt}, {28'd0, eg});
        last_gnt = gnt;
        if (q.size() != 0 && out_ready) begin
            void'(q.pop_front());
        end
        if (k >= 0) begin
            am = din_mag[k*W +: W];
            a = din_sign[k] ? -int'(am) : int'(am);
            b = m_sgn[k] ? -m_mag[k] : m_mag[k];
            d = a - b;
            ab = (d < 0) ? -d : d;
            e.sign = (d < 0);
            e.ovf = (ab > MAXM);
            e.mag = e.ovf ? W'(MAXM) : W'(ab);
            e.ch = 2'(k);
            q.push_back(e);
            m_mag[k] = int'(am);
            m_sgn[k] = din_sign[k] && (am != '0);
            m_ptr = (k + 1) % NCH;
        end
        if (clr_hist) begin
            model_clear();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        req = '1;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mag", {16'd0, out_mag}, 32'd0);
        chk("rst_sign", {31'd0, out_sign}, 32'd0);
        chk("rst_ch", {30'd0, out_ch}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        q.delete();
        model_clear();
        m_ptr = 0;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic one(input int k, input logic [W-1:0] m, input logic s);
        req = '0;
        req[k] = 1'b1;
        set_ch(k, m, s);
        tick();
        req = '0;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] m,
                              input logic s, input logic o);
        chk({tag, "_mag"}, {16'd0, out_mag}, {16'd0, m});
        chk({tag, "_sign"}, {31'd0, out_sign}, {31'd0, s});
        chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
    endtask

    initial begin
        #2;
        hard_reset();
        out_ready = 1'b1;

        one(0, 16'd100, 1'b0);
        expect_out("c0a", 16'd100, 1'b0, 1'b0);
        one(0, 16'd250, 1'b0);
        expect_out("c0b", 16'd150, 1'b0, 1'b0);
        one(0, 16'd200, 1'b0);
        expect_out("c0c", 16'd50, 1'b1, 1'b0);

        one(1, 16'd30, 1'b0);
        expect_out("c1a", 16'd30, 1'b0, 1'b0);
        one(1, 16'd40, 1'b1);
        expect_out("c1b", 16'd70, 1'b1, 1'b0);
        one(1, 16'd40, 1'b1);
        expect_out("c1z", 16'd0, 1'b0, 1'b0);

        one(2, 16'd65000, 1'b0);
        expect_out("c2a", 16'd65000, 1'b0, 1'b0);
        one(2, 16'd1000, 1'b1);
        expect_out("sat", 16'hFFFF, 1'b1, 1'b1);
        chk("sat_ch", {30'd0, out_ch}, 32'd2);
        tick();

        hard_reset();
        for (int c = 0; c < NCH; c++) begin
            set_ch(c, W'(1000 * (c + 1)), c[0]);
        end
        req = '1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_order", {28'd0, last_gnt}, 32'd1 << (i % 4));
            chk("rr_ch", {30'd0, out_ch}, i % 4);
        end

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_gnt", {28'd0, last_gnt}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_resume", {28'd0, last_gnt}, 32'd2);
        req = '0;
        tick();

        one(3, 16'd500, 1'b0);
        clr_hist = 1'b1;
        tick();
        clr_hist = 1'b0;
        one(3, 16'd20, 1'b0);
        expect_out("clr", 16'd20, 1'b0, 1'b0);
        one(3, 16'd700, 1'b0);
        clr_hist = 1'b1;
        one(3, 16'd100, 1'b0);
        clr_hist = 1'b0;
        expect_out("clr_same", 16'd600, 1'b1, 1'b0);
        one(3, 16'd5, 1'b0);
        expect_out("clr_win", 16'd5, 1'b0, 1'b0);
        tick();

        out_ready = 1'b0;
        one(0, 16'd9, 1'b0);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        hard_reset();
        out_ready = 1'b1;

        pend = '0;
        last_gnt = '0;
        repeat (300) begin
            for (int c = 0; c < NCH; c++) begin
                if (last_gnt[c]) begin
                    pend[c] = 1'b0;
                end
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    case ($urandom_range(0, 3))
                        0: set_ch(c, W'($urandom_range(64000, MAXM)), 1'($urandom_range(0, 1)));
                        1: set_ch(c, '0, 1'($urandom_range(0, 1)));
                        default: set_ch(c, W'($urandom_range(0, 3000)), 1'($urandom_range(0, 1)));
                    endcase
                end
            end
            req = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            clr_hist = ($urandom_range(0, 15) == 0);
            tick();
        end
        req = '0;
        clr_hist = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddiff_arb.md
Name: ddiff_arb

Overview:
- Shares one registered sign-magnitude delayed-difference datapath (C = A(n) - A(n-1)) among NCH sample sources in the anspwm pipeline.
- Each channel keeps its own history sample; a round-robin arbiter grants one requesting channel per accepted cycle.
- The difference is returned with a channel tag through a single-entry output register with valid/ready backpressure.
- Sits between the per-channel sample producers and the noise-shaping/PWM stages.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- W, 16, magnitude width of samples and results.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NCH  per-channel request; sample on din_* is valid while high.
- din_mag  in  NCH*W  packed magnitudes; channel k occupies bits [k*W +: W].
- din_sign  in  NCH  per-channel sign, 1 = negative.
- gnt  out  NCH  one-hot, combinational; the granted channel's sample is consumed this cycle.
- clr_hist  in  1  synchronous clear of all history registers.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result when out_valid && out_ready.
- out_mag  out  W  result magnitude.
- out_sign  out  1  result sign, 1 = negative; never 1 when out_mag == 0.
- out_ch  out  $clog2(NCH)  channel that produced the result.
- out_ovf  out  1  result magnitude saturated.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_mag=0, out_sign=0, out_ch=0, out_ovf=0.
  - All history registers = +0.
  - Round-robin pointer = 0; FSM enters IDLE.
  - gnt=0 while rst is high.
- Accept condition: can_accept = !out_valid || out_ready.
  - If can_accept and req != 0, gnt is the one-hot of the first requester at or after the pointer, scanning upward with wrap.
  - Otherwise gnt = 0.
- Arbitration: on a grant to channel k, the pointer becomes (k+1) mod NCH. With no grant, the pointer holds.
- FSM:
  - IDLE: out_valid=0. A grant moves to FULL.
  - FULL: out_valid=1.
    - out_ready with a new grant: stay in FULL and load the new result.
    - out_ready with no grant: go to IDLE.
    - !out_ready: hold all outputs stable.
- Latency: a grant in cycle N gives out_valid=1 with that result from the rising edge ending cycle N. One result per cycle is sustained when out_ready=1.
- Arithmetic: A = granted sample, B = history[k], both sign-magnitude.
  - Same signs: magnitude |A-B|. Sign = A's sign when A >= B, else the inverse of A's sign.
  - Different signs: magnitude A+B computed at W+1 bits. Sign = A's sign.
    - If the sum is >= 2^W, out_mag = 2^W-1 and out_ovf = 1.
    - Otherwise out_ovf = 0.
  - Zero normalisation: if the magnitude is 0, the sign is 0.
- History update: on a grant, history[k] <= A, with sign stored as given; -0 is stored as +0. Non-granted histories are unchanged.
- clr_hist:
  - Sets all histories to +0 at the clock edge.
  - If a grant occurs in the same cycle, that result uses the pre-clear history, and the clear wins for the granted channel's history (+0).
- Simultaneous out_ready and grant: the old result is retired and the new result is loaded at the same edge; no bubble and no duplicate.
- Reset mid-operation: a pending result is discarded and histories are lost.
- A request not granted is not consumed; the requester holds req and din_* until it sees gnt.

Test Plan:
- Reset then single channel 0, samples +100, +250, +200 with out_ready=1 → results (+100, ch0), (+150, ch0), (-50, ch0), each one cycle after its gnt.
- Sign crossing on ch1: +30 then -40 → second result mag 70, sign 1. Then -40 again → mag 0, sign 0 (no -0).
- Saturation on ch2: +65000 then -1000 → out_mag=65535, out_sign=1, out_ovf=1.
- All four channels requesting continuously, out_ready=1 → gnt order ch0, ch1, ch2, ch3, ch0, with one result per cycle and out_ch matching.
- Backpressure: out_ready=0 for 3 cycles with req active → gnt=0 and out_* stable. Raising out_ready gives a grant and new result in the same cycle.
- clr_hist plus reset mid-stream:
  - ch3 history +500; assert clr_hist; next ch3 sample +20 → result +20.
  - Assert rst while out_valid=1 → all outputs 0 immediately.
